cpu_sequencer: RTL and testbench

//  Parametrised M-cycle sequencer for the SM83 core. Tracks the opcode register and step count.

---
 rtl/cpu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// M-cycle sequencer for the SM83 core: opcode register, step counter, CB prefix, HALT and IRQ dispatch.
// Optional feature macro: SEQ_HALT_BUG_EN (DMG HALT bug, adds the pc_hold output).
module cpu_sequencer #(
  parameter int         STEP_W     = 3,
  parameter int         IRQ_N      = 5,
  parameter int         IRQ_LEN    = 5,
  parameter logic [7:0] VEC_BASE   = 8'h40,
  parameter int         VEC_STRIDE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        d_in,
  input  logic              done,
  input  logic              is_cond,
  input  logic              next_cond,
  input  logic              halt_req,
  input  logic              ime,
  input  logic [IRQ_N-1:0]  ie,
  input  logic [IRQ_N-1:0]  if_in,
  output logic [7:0]        ir,
  output logic              cb,
  output logic [STEP_W-1:0] step,
  output logic              in_irq,
  output logic [7:0]        irq_vec,
  output logic [IRQ_N-1:0]  irq_ack,
  output logic              halted,
  output logic              seq_err
`ifdef SEQ_HALT_BUG_EN
  ,
  output logic              pc_hold
`endif
);

  localparam int                SEL_W     = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] IRQ_LAST  = STEP_W'(IRQ_LEN - 1);
  localparam logic [STEP_W-1:0] IRQ_PEN   = STEP_W'(IRQ_LEN - 2);

  // PFX is the second-byte fetch of a CB prefix; WAKE is the cycle after HALT exits.
  typedef enum logic [2:0] {S_EXEC, S_PFX, S_IRQ, S_HALT, S_WAKE} state_t;

  state_t            state, state_n;
  logic [7:0]        ir_n, irq_vec_n, vec_calc;
  logic              cb_n, seq_err_n, hold_n, do_fetch, do_irq, end_i, any_pend;
  logic [STEP_W-1:0] step_n;
  logic [IRQ_N-1:0]  pend, ack_n;
  logic [SEL_W-1:0]  sel, sel_q, sel_n;

  assign pend     = ie & if_in;
  assign any_pend = |pend;
  assign end_i    = done | (is_cond & ~next_cond);
  assign vec_calc = VEC_BASE + 8'(int'(sel) * VEC_STRIDE);

  always_comb begin
    sel = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (pend[i]) sel = SEL_W'(i);
    end
  end

  always_comb begin
    state_n   = state;
    ir_n      = ir;
    cb_n      = cb;
    step_n    = step;
    irq_vec_n = irq_vec;
    sel_n     = sel_q;
    ack_n     = '0;
    seq_err_n = seq_err;
    hold_n    = 1'b0;
    do_fetch  = 1'b0;
    do_irq    = 1'b0;
    case (state)
      S_EXEC: begin
        if (!end_i) begin
          if (step == STEP_MAX) begin
            seq_err_n = 1'b1;
            do_fetch  = 1'b1;
          end else begin
            step_n = step + STEP_W'(1);
          end
        end else if (ime && any_pend) begin
          do_irq = 1'b1;
        end else if (halt_req && !any_pend) begin
          state_n = S_HALT;
          step_n  = '0;
        end else if (halt_req) begin
          do_fetch = 1'b1;
          hold_n   = 1'b1;
        end else if (d_in == 8'hCB && !cb) begin
          ir_n    = 8'hCB;
          cb_n    = 1'b1;
          step_n  = '0;
          state_n = S_PFX;
        end else begin
          do_fetch = 1'b1;
        end
      end
      S_PFX: begin
        ir_n    = d_in;
        cb_n    = 1'b1;
        step_n  = '0;
        state_n = S_EXEC;
      end
      S_IRQ: begin
        if (step == IRQ_LAST) begin
          do_fetch = 1'b1;
        end else begin
          step_n = step + STEP_W'(1);
          // Registered one step early so the pulse lines up with the final dispatch step.
          if (step == IRQ_PEN) ack_n = IRQ_N'(1) << sel_q;
        end
      end
      S_HALT: begin
        step_n = '0;
        if (any_pend) state_n = S_WAKE;
      end
      S_WAKE: begin
        if (ime && any_pend) begin
          do_irq = 1'b1;
        end else begin
          do_fetch = 1'b1;
          hold_n   = ~ime;
        end
      end
      default: state_n = S_EXEC;
    endcase
    if (do_irq) begin
      state_n   = S_IRQ;
      step_n    = '0;
      irq_vec_n = vec_calc;
      sel_n     = sel;
    end
    if (do_fetch) begin
      state_n = S_EXEC;
      ir_n    = d_in;
      cb_n    = 1'b0;
      step_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_EXEC;
      ir      <= 8'h00;
      cb      <= 1'b0;
      step    <= '0;
      in_irq  <= 1'b0;
      irq_vec <= VEC_BASE;
      irq_ack <= '0;
      halted  <= 1'b0;
      seq_err <= 1'b0;
      sel_q   <= '0;
    end else begin
      state   <= state_n;
      ir      <= ir_n;
      cb      <= cb_n;
      step    <= step_n;
      in_irq  <= (state_n == S_IRQ);
      irq_vec <= irq_vec_n;
      irq_ack <= ack_n;
      halted  <= (state_n == S_HALT);
      seq_err <= seq_err_n;
      sel_q   <= sel_n;
    end
  end

`ifdef SEQ_HALT_BUG_EN
  always_ff @(posedge clk) begin
    if (reset) pc_hold <= 1'b0;
    else       pc_hold <= hold_n;
  end
`else
  logic unused_hold;
  assign unused_hold = hold_n;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: default instance plus a STEP_W=2 instance for overflow.
// Observed outputs are packed as {ir, cb, step, in_irq, halted, seq_err, irq_vec, irq_ack, pc_hold}.
module tb_cpu_sequencer;

`ifdef SEQ_HALT_BUG_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       done = 1'b0, is_cond = 1'b0, next_cond = 1'b0, halt_req = 1'b0, ime = 1'b0;
  logic [4:0] ie = '0, if_in = '0;

  logic [7:0] ir, irq_vec, ir2, irq_vec2;
  logic       cb, in_irq, halted, seq_err, cb2, in_irq2, halted2, seq_err2;
  logic [2:0] step;
  logic [1:0] step2;
  logic [4:0] irq_ack, irq_ack2;
  logic       hold1, hold2;

  logic [28:0] exp_q[$];
  logic [28:0] got_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_sel = 1'b0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .d_in(d_in), .done(done), .is_cond(is_cond),
    .next_cond(next_cond), .halt_req(halt_req), .ime(ime), .ie(ie), .if_in(if_in),
    .ir(ir), .cb(cb), .step(step), .in_irq(in_irq), .irq_vec(irq_vec),
    .irq_ack(irq_ack), .halted(halted), .seq_err(seq_err)
`ifdef SEQ_HALT_BUG_EN
    , .pc_hold(hold1)
`endif
  );

  cpu_sequencer #(.STEP_W(2), .IRQ_LEN(4)) dut_s (
    .clk(clk), .reset(reset), .d_in(d_in), .done(done), .is_cond(is_cond),
    .next_cond(next_cond), .halt_req(halt_req), .ime(ime), .ie(ie), .if_in(if_in),
    .ir(ir2), .cb(cb2), .step(step2), .in_irq(in_irq2), .irq_vec(irq_vec2),
    .irq_ack(irq_ack2), .halted(halted2), .seq_err(seq_err2)
`ifdef SEQ_HALT_BUG_EN
    , .pc_hold(hold2)
`endif
  );

`ifndef SEQ_HALT_BUG_EN
  assign hold1 = 1'b0;
  assign hold2 = 1'b0;
`endif

  // {done, d_in, expected ir, expected cb, expected step}
  localparam logic [20:0] MULTI_TBL [10] = '{
    {1'b0, 8'h00, 8'h11, 1'b0, 3'd1}, {1'b0, 8'h00, 8'h11, 1'b0, 3'd2},
    {1'b1, 8'hCB, 8'hCB, 1'b1, 3'd0}, {1'b1, 8'h7C, 8'h7C, 1'b1, 3'd0},
    {1'b0, 8'h00, 8'h7C, 1'b1, 3'd1}, {1'b1, 8'h3C, 8'h3C, 1'b0, 3'd0},
    {1'b1, 8'hCB, 8'hCB, 1'b1, 3'd0}, {1'b0, 8'hCB, 8'hCB, 1'b1, 3'd0},
    {1'b0, 8'h00, 8'hCB, 1'b1, 3'd1}, {1'b1, 8'h00, 8'h00, 1'b0, 3'd0}
  };

  function automatic logic [28:0] ex(input logic [7:0] i, input logic c, input logic [2:0] s,
                                     input logic q, input logic h, input logic e,
                                     input logic [7:0] v, input logic [4:0] a, input logic p);
    return {i, c, s, q, h, e, v, a, p & HB};
  endfunction

  // Driver: applies one cycle of inputs, queues the expectation, captures the result after the edge.
  task automatic drive(input logic dn, input logic ic, input logic nc, input logic hr,
                       input logic im, input logic [4:0] e, input logic [4:0] f,
                       input logic [7:0] d, input logic [28:0] x);
    done = dn; is_cond = ic; next_cond = nc; halt_req = hr; ime = im;
    ie = e; if_in = f; d_in = d;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    if (mon_sel) got_q.push_back({ir2, cb2, 1'b0, step2, in_irq2, halted2, seq_err2, irq_vec2, irq_ack2, hold2});
    else         got_q.push_back({ir, cb, step, in_irq, halted, seq_err, irq_vec, irq_ack, hold1});
  endtask

  task automatic test_reset;
    logic [28:0] x, g;
    reset = 1'b1;
    mon_sel = 1'b0;
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h3C, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    mon_sel = 1'b1;
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h3C, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    mon_sel = 1'b0;
    reset = 1'b0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL reset[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_fetch;
    logic [28:0] x, g;
    logic [7:0]  d;
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h3C, ex(8'h3C, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h04, ex(8'h04, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      if (d == 8'hCB) d = 8'h3C;
      drive(1, 0, 0, 0, 0, 5'h00, 5'h00, d, ex(d, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    end
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h11, ex(8'h11, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL fetch[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_multi_cb;
    logic [28:0] x, g;
    logic [20:0] row;
    for (int i = 0; i < 10; i++) begin
      row = MULTI_TBL[i];
      drive(row[20], 0, 0, 0, 0, 5'h00, 5'h00, row[19:12],
            ex(row[11:4], row[3], row[2:0], 0, 0, 0, 8'h40, 5'h00, 0));
    end
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL multi_cb[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_cond;
    logic [28:0] x, g;
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd1, 0, 0, 0, 8'h40, 5'h00, 0));
    drive(0, 1, 0, 0, 0, 5'h00, 5'h00, 8'h21, ex(8'h21, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h21, 0, 3'd1, 0, 0, 0, 8'h40, 5'h00, 0));
    drive(0, 1, 1, 0, 0, 5'h00, 5'h00, 8'h99, ex(8'h21, 0, 3'd2, 0, 0, 0, 8'h40, 5'h00, 0));
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL cond[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_irq;
    logic [28:0] x, g;
    logic [7:0]  cur_ir, vec, ret;
    logic [4:0]  e, f, ack;
    cur_ir = 8'h00;
    for (int k = 0; k < 2; k++) begin
      e   = (k == 0) ? 5'b11111 : 5'b11110;
      f   = (k == 0) ? 5'b00100 : 5'b11011;
      vec = (k == 0) ? 8'h50 : 8'h48;
      ack = (k == 0) ? 5'b00100 : 5'b00010;
      ret = (k == 0) ? 8'h77 : 8'h66;
      drive(1, 0, 0, 0, 1, e, f, 8'h55, ex(cur_ir, 0, 3'd0, 1, 0, 0, vec, 5'h00, 0));
      for (int s = 1; s < 5; s++) begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0, e, 5'b00001, 8'hEE,
              ex(cur_ir, 0, 3'(s), 1, 0, 0, vec, (s == 4) ? ack : 5'h00, 0));
      end
      drive(0, 0, 0, 0, 0, 5'h00, 5'h00, ret, ex(ret, 0, 3'd0, 0, 0, 0, vec, 5'h00, 0));
      cur_ir = ret;
    end
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL irq[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_halt;
    logic [28:0] x, g;
    drive(1, 0, 0, 1, 0, 5'h1F, 5'h00, 8'h99, ex(8'h66, 0, 3'd0, 0, 1, 0, 8'h48, 5'h00, 0));
    drive(1, 0, 0, 1, 0, 5'h1F, 5'h00, 8'hAA, ex(8'h66, 0, 3'd0, 0, 1, 0, 8'h48, 5'h00, 0));
    drive(0, 0, 0, 0, 0, 5'h1F, 5'h01, 8'hAA, ex(8'h66, 0, 3'd0, 0, 0, 0, 8'h48, 5'h00, 0));
    drive(0, 0, 0, 0, 0, 5'h1F, 5'h01, 8'h3E, ex(8'h3E, 0, 3'd0, 0, 0, 0, 8'h48, 5'h00, 1));
    // HALT with a pending source and ime=0 is skipped.
    drive(1, 0, 0, 1, 0, 5'h1F, 5'h01, 8'h12, ex(8'h12, 0, 3'd0, 0, 0, 0, 8'h48, 5'h00, 1));
    drive(1, 0, 0, 1, 0, 5'h1F, 5'h00, 8'h34, ex(8'h12, 0, 3'd0, 0, 1, 0, 8'h48, 5'h00, 0));
    drive(0, 0, 0, 0, 1, 5'h1F, 5'h08, 8'h56, ex(8'h12, 0, 3'd0, 0, 0, 0, 8'h48, 5'h00, 0));
    drive(0, 0, 0, 0, 1, 5'h1F, 5'h08, 8'h56, ex(8'h12, 0, 3'd0, 1, 0, 0, 8'h58, 5'h00, 0));
    for (int s = 1; s < 5; s++) begin
      drive(0, 0, 0, 0, 0, 5'h1F, 5'h00, 8'hEE,
            ex(8'h12, 0, 3'(s), 1, 0, 0, 8'h58, (s == 4) ? 5'b01000 : 5'h00, 0));
    end
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h5A, ex(8'h5A, 0, 3'd0, 0, 0, 0, 8'h58, 5'h00, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL halt[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_overflow;
    logic [28:0] x, g;
    mon_sel = 1'b1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    reset = 1'b0;
    for (int s = 1; s < 4; s++) begin
      drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'(s), 0, 0, 0, 8'h40, 5'h00, 0));
    end
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'hAB, ex(8'hAB, 0, 3'd0, 0, 0, 1, 8'h40, 5'h00, 0));
    drive(1, 0, 0, 0, 0, 5'h00, 5'h00, 8'h01, ex(8'h01, 0, 3'd0, 0, 0, 1, 8'h40, 5'h00, 0));
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h01, 0, 3'd1, 0, 0, 1, 8'h40, 5'h00, 0));
    drive(1, 0, 0, 0, 1, 5'h1F, 5'h02, 8'h77, ex(8'h01, 0, 3'd0, 1, 0, 1, 8'h48, 5'h00, 0));
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h01, 0, 3'd1, 1, 0, 1, 8'h48, 5'h00, 0));
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h01, 0, 3'd2, 1, 0, 1, 8'h48, 5'h00, 0));
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd1, 0, 0, 0, 8'h40, 5'h00, 0));
    mon_sel = 1'b0;
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL overflow[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  task automatic test_reset_abort;
    logic [28:0] x, g;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    reset = 1'b0;
    drive(1, 0, 0, 1, 0, 5'h1F, 5'h00, 8'h22, ex(8'h00, 0, 3'd0, 0, 1, 0, 8'h40, 5'h00, 0));
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5'h1F, 5'h00, 8'h00, ex(8'h00, 0, 3'd0, 0, 0, 0, 8'h40, 5'h00, 0));
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 5'h00, 5'h00, 8'h00, ex(8'h00, 0, 3'd1, 0, 0, 0, 8'h40, 5'h00, 0));
    for (int n = 0; exp_q.size() > 0; n++) begin
      x = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== x) begin errors++; $display("FAIL reset_abort[%0d] got %h exp %h", n, g, x); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_multi_cb();
    test_cond();
    test_irq();
    test_halt();
    test_overflow();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
